// File: rtl/siso_arbiter.sv
// Two-requester round-robin arbiter in front of one shared SISO decoder core.
// Latches the winner's operands, launches the core, waits with a timeout, then responds.
module siso_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk_p_i,
    input  logic         reset_n_i,
    input  logic [1:0]   req_i,
    input  logic [27:0]  sys0_i,
    input  logic [27:0]  sys1_i,
    input  logic [27:0]  enc0_i,
    input  logic [27:0]  enc1_i,
    input  logic [69:0]  ext0_i,
    input  logic [69:0]  ext1_i,
    output logic         siso_read_en_o,
    output logic [27:0]  siso_sys_o,
    output logic [27:0]  siso_enc_o,
    output logic [69:0]  siso_ext_o,
    input  logic         siso_finish_i,
    input  logic [69:0]  siso_data_i,
    output logic [1:0]   gnt_o,
    output logic [1:0]   done_o,
    output logic [69:0]  data_o,
    output logic         busy_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last;
    logic [1:0]        r_gnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [27:0]       r_sys;
    logic [27:0]       r_enc;
    logic [69:0]       r_ext;
    logic [69:0]       r_data;
    logic              r_timeout;
    logic              w_sel;
    logic              w_hit;

    // On a tie the requester that did not own the core last time wins.
    always_comb begin
        w_sel = 1'b0;
        unique case (req_i)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (|req_i) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (siso_finish_i || w_hit) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_gnt     <= 2'b00;
            r_cnt     <= '0;
            r_sys     <= '0;
            r_enc     <= '0;
            r_ext     <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (|req_i) begin
                        r_owner <= w_sel;
                        r_gnt   <= w_sel ? 2'b10 : 2'b01;
                        r_sys   <= w_sel ? sys1_i : sys0_i;
                        r_enc   <= w_sel ? enc1_i : enc0_i;
                        r_ext   <= w_sel ? ext1_i : ext0_i;
                    end
                end
                S_LAUNCH: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A finish on the last allowed cycle beats the timeout.
                    if (siso_finish_i) begin
                        r_data <= siso_data_i;
                    end else if (w_hit) begin
                        r_data    <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_last <= r_owner;
                    r_gnt  <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign siso_read_en_o = (r_state == S_LAUNCH);
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_RESP) ? r_gnt : 2'b00;
    assign gnt_o          = r_gnt;
    assign siso_sys_o     = r_sys;
    assign siso_enc_o     = r_enc;
    assign siso_ext_o     = r_ext;
    assign data_o         = r_data;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_siso_arbiter.sv
// Self-checking bench for siso_arbiter: directed cases plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_siso_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [27:0] sys0, sys1, enc0, enc1;
    logic [69:0] ext0, ext1;
    logic        rd_en;
    logic [27:0] s_sys, s_enc;
    logic [69:0] s_ext;
    logic        fin;
    logic [69:0] fdata;
    logic [1:0]  gnt, done;
    logic [69:0] dout;
    logic        busy, tmo;

    int total = 0;
    int bad   = 0;
    int last  = 1;

    siso_arbiter #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk_p_i        (clk),
        .reset_n_i      (rst_n),
        .req_i          (req),
        .sys0_i         (sys0),
        .sys1_i         (sys1),
        .enc0_i         (enc0),
        .enc1_i         (enc1),
        .ext0_i         (ext0),
        .ext1_i         (ext1),
        .siso_read_en_o (rd_en),
        .siso_sys_o     (s_sys),
        .siso_enc_o     (s_enc),
        .siso_ext_o     (s_ext),
        .siso_finish_i  (fin),
        .siso_data_i    (fdata),
        .gnt_o          (gnt),
        .done_o         (done),
        .data_o         (dout),
        .busy_o         (busy),
        .timeout_o      (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [69:0] obs,
                       input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] r70();
        return {6'($urandom), $urandom, $urandom};
    endfunction

    task automatic rand_ops();
        sys0 = 28'($urandom);
        sys1 = 28'($urandom);
        enc0 = 28'($urandom);
        enc1 = 28'($urandom);
        ext0 = r70();
        ext1 = r70();
    endtask

    // Round-robin: a lone requester wins; a tie goes to the non-last owner.
    function automatic int pick(input logic [1:0] r, input int lst);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (lst == 0) ? 1 : 0;
    endfunction

    // One full transaction starting in IDLE. f = WAIT cycle carrying
    // finish (values outside 1..TO mean the core never answers).
    task automatic txn(input logic [1:0] r, input int f, input logic [69:0] d);
        int          own;
        logic [1:0]  eg;
        logic [27:0] es, ee;
        logic [69:0] ex, ed;
        logic        et;
        own = pick(r, last);
        eg  = (own == 1) ? 2'b10 : 2'b01;
        es  = (own == 1) ? sys1 : sys0;
        ee  = (own == 1) ? enc1 : enc0;
        ex  = (own == 1) ? ext1 : ext0;
        et  = !(f >= 1 && f <= TO);
        ed  = et ? 70'h0 : d;
        req = r;
        tick();
        chk("launch_rd_en", rd_en, 1'b1);
        chk("launch_gnt", gnt, eg);
        chk("launch_sys", s_sys, es);
        chk("launch_enc", s_enc, ee);
        chk("launch_ext", s_ext, ex);
        rand_ops();
        req   = 2'($urandom);
        fin   = 1'($urandom);
        fdata = r70();
        for (int k = 1; k <= TO; k++) begin
            tick();
            fin = 1'b0;
            chk("wait_rd_en", rd_en, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_done", done, 2'b00);
            if (k == 1 || k == TO) chk("wait_sys_hold", s_sys, es);
            if (k == f) begin
                fin   = 1'b1;
                fdata = d;
                break;
            end
        end
        tick();
        fin   = 1'($urandom);
        fdata = r70();
        chk("resp_done", done, eg);
        chk("resp_timeout", tmo, et);
        chk("resp_data", dout, ed);
        chk("resp_ext_hold", s_ext, ex);
        last = own;
        tick();
        fin = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 2'b00);
        chk("idle_gnt", gnt, 2'b00);
        chk("idle_data_hold", dout, ed);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'($urandom);
        fin   = 1'b1;
        fdata = r70();
        rand_ops();
        #23;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_data", dout, 70'h0);
        chk("rst_sys", s_sys, 28'h0);
        chk("rst_ext", s_ext, 70'h0);
        tick();
        req   = 2'b00;
        fin   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_after_rst", busy, 1'b0);
        end

        sys0 = 28'h123_4567;
        txn(2'b01, 5, 70'h15);

        rst_n = 1'b0;
        last  = 1;
        tick();
        req   = 2'b11;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) txn(2'b11, 1, r70());

        txn(2'b10, 1000, r70());
        txn(2'b01, TO, 70'h3FF);

        req = 2'b01;
        tick();
        tick();
        tick();
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_gnt", gnt, 2'b00);
        chk("midrst_data", dout, 70'h0);
        chk("midrst_sys", s_sys, 28'h0);
        last = 1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        fin   = 1'b1;
        fdata = r70();
        tick();
        fin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_fin_done", done, 2'b00);
            chk("late_fin_busy", busy, 1'b0);
            chk("late_fin_data", dout, 70'h0);
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0] r;
            int         f;
            rand_ops();
            r = 2'($urandom_range(1, 3));
            f = $urandom_range(1, TO + 4);
            if (i % 6 == 5) f = TO;
            txn(r, f, r70());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
